// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and RAM-port bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32 load/store unit in front of a 1-cycle-latency RAM
module load_store_unit #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct_q;
  logic [1:0]            lane_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [31:0]           rsp_rdata_q;

  logic                  accept;
  logic                  req_err;
  logic [1:0]            lane;
  logic [3:0]            wmask;
  logic [31:0]           wdata_rep;
  logic [31:0]           shifted;
  logic [31:0]           load_d;
  logic                  unused_addr_bits;

  assign lane             = bus.req_addr[1:0];
  assign bus.req_ready    = (state_q == IDLE) && !reset;
  assign accept           = bus.req_valid && bus.req_ready;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

  // Decode legality, byte mask and lane-replicated store data for the request on the bus.
  always_comb begin
    req_err   = 1'b0;
    wmask     = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (bus.req_funct)
      3'b000: begin
        wmask     = 4'b0001 << lane;
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      3'b001: begin
        req_err   = lane[0];
        wmask     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      3'b010: begin
        req_err = |lane;
        wmask   = 4'b1111;
      end
      3'b100:  req_err = bus.req_write;
      3'b101:  req_err = bus.req_write | lane[0];
      default: req_err = 1'b1;
    endcase
  end

  assign bus.mem_we    = (accept && bus.req_write && !req_err) ? wmask : 4'b0000;
  assign bus.mem_wdata = wdata_rep;
  assign bus.mem_addr  = (state_q == IDLE) ? bus.req_addr[ADDR_WIDTH+1:2] : addr_q;

  // Load extraction uses the lane latched at accept, since req_addr may have moved on.
  always_comb begin
    shifted = bus.mem_rdata >> {lane_q, 3'b000};
    case (funct_q)
      3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_d = {24'h000000, shifted[7:0]};
      3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_d = {16'h0000, shifted[15:0]};
      default: load_d = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      funct_q     <= 3'b000;
      lane_q      <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
            funct_q <= bus.req_funct;
            lane_q  <= lane;
            if (req_err || bus.req_write) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= req_err;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= load_d;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int AW = 9;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  logic [31:0] ram [0:(1<<AW)-1];

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read of the presented address, byte-enabled write.
  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_funct = f;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
  endtask

  task automatic accept_edge();
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678);
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 4'b0000) $display("FAIL reset_mem_we got %b want 0000", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_error !== 1'b0) $display("FAIL reset_rsp_error got %b want 0", bus.rsp_error); else pass_cnt++;
    total_cnt++; if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); else pass_cnt++;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_store_word();
    drive(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    total_cnt++; if (bus.mem_we !== 4'b1111) $display("FAIL sw_mem_we got %b want 1111", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 9'd4) $display("FAIL sw_mem_addr got %0d want 4", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_mem_wdata got %h want deadbeef", bus.mem_wdata); else pass_cnt++;
    accept_edge();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0) $display("FAIL sw_rsp got v=%b e=%b want v=1 e=0", bus.rsp_valid, bus.rsp_error); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 4'b0000 || bus.req_ready !== 1'b0) $display("FAIL sw_n1_idle got we=%b rdy=%b want 0000/0", bus.mem_we, bus.req_ready); else pass_cnt++;
    handshake();
    total_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL sw_after_hs got v=%b rdy=%b want 0/1", bus.rsp_valid, bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_byte();
    drive(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00AB);
    total_cnt++; if (bus.mem_we !== 4'b1000) $display("FAIL sb_mem_we got %b want 1000", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 32'hABAB_ABAB) $display("FAIL sb_mem_wdata got %h want abababab", bus.mem_wdata); else pass_cnt++;
    accept_edge();
    handshake();
    drive(1'b0, 3'b000, 32'h0000_0013, 32'h0);
    accept_edge();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL lb_n1_valid got %b want 0", bus.rsp_valid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFF_FFAB) $display("FAIL lb_rsp got v=%b d=%h want 1 ffffffab", bus.rsp_valid, bus.rsp_rdata); else pass_cnt++;
    handshake();
    drive(1'b0, 3'b100, 32'h0000_0013, 32'h0);
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_rdata !== 32'h0000_00AB) $display("FAIL lbu_rsp got %h want 000000ab", bus.rsp_rdata); else pass_cnt++;
    handshake();
  endtask

  task automatic test_half();
    drive(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001);
    total_cnt++; if (bus.mem_we !== 4'b1100) $display("FAIL sh_mem_we got %b want 1100", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 32'h8001_8001) $display("FAIL sh_mem_wdata got %h want 80018001", bus.mem_wdata); else pass_cnt++;
    accept_edge();
    handshake();
    drive(1'b0, 3'b001, 32'h0000_0022, 32'h0);
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_rdata !== 32'hFFFF_8001) $display("FAIL lh_rsp got %h want ffff8001", bus.rsp_rdata); else pass_cnt++;
    handshake();
    drive(1'b0, 3'b101, 32'h0000_0022, 32'h0);
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_rdata !== 32'h0000_8001) $display("FAIL lhu_rsp got %h want 00008001", bus.rsp_rdata); else pass_cnt++;
    handshake();
  endtask

  task automatic test_errors();
    drive(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    total_cnt++; if (bus.mem_we !== 4'b0000) $display("FAIL lw_mis_mem_we got %b want 0000", bus.mem_we); else pass_cnt++;
    accept_edge();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0)
      $display("FAIL lw_mis_rsp got v=%b e=%b d=%h want 1 1 0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); else pass_cnt++;
    handshake();
    drive(1'b1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF);
    total_cnt++; if (bus.mem_we !== 4'b0000) $display("FAIL sbu_mem_we got %b want 0000", bus.mem_we); else pass_cnt++;
    accept_edge();
    total_cnt++; if (bus.rsp_error !== 1'b1) $display("FAIL sbu_err got %b want 1", bus.rsp_error); else pass_cnt++;
    handshake();
    drive(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    accept_edge();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1) $display("FAIL f011_rsp got v=%b e=%b want 1 1", bus.rsp_valid, bus.rsp_error); else pass_cnt++;
    handshake();
    drive(1'b1, 3'b001, 32'h0000_0021, 32'h1111);
    total_cnt++; if (bus.mem_we !== 4'b0000) $display("FAIL sh_odd_mem_we got %b want 0000", bus.mem_we); else pass_cnt++;
    accept_edge();
    handshake();
  endtask

  task automatic test_wrap();
    drive(1'b0, 3'b010, 32'hFFFF_F810, 32'h0);
    total_cnt++; if (bus.mem_addr !== 9'd4) $display("FAIL wrap_mem_addr got %0d want 4", bus.mem_addr); else pass_cnt++;
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_rdata !== 32'hABAD_BEEF) $display("FAIL wrap_lw got %h want abadbeef", bus.rsp_rdata); else pass_cnt++;
    handshake();
  endtask

  task automatic test_backpressure();
    drive(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    accept_edge();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hABAD_BEEF || bus.req_ready !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want 1 abadbeef 0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      else pass_cnt++;
    end
    handshake();
    total_cnt++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL bp_idle got rdy=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    drive(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
    accept_edge();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) $display("FAIL b2b_hs got v=%b rdy=%b want 1 0", bus.rsp_valid, bus.req_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", bus.req_ready); else pass_cnt++;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_funct = 3'b010;
    bus.req_addr  = 32'h0000_0040;
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D) $display("FAIL b2b_lw got v=%b d=%h want 1 cafef00d", bus.rsp_valid, bus.rsp_rdata); else pass_cnt++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_in_load();
    drive(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    accept_edge();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL rst_load got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_no_replay got %b want 0", bus.rsp_valid); else pass_cnt++;
    drive(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    accept_edge();
    @(negedge clk); #1;
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h8001_0000) $display("FAIL rst_lw got v=%b d=%h want 1 80010000", bus.rsp_valid, bus.rsp_rdata); else pass_cnt++;
    handshake();
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_errors();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_in_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
